// File: rtl/tone_sq_wave_gen.sv
// tone_sq_wave_gen: square-wave tone source for the audio PWM DAC path.
// Emits a CODE_WIDTH-bit code swinging +/-amp around MID_CODE, stepping
// only on next_sample. Period/amplitude are reprogrammed through a
// one-deep valid/ready slot and applied only at phase boundaries.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   next_sample         one-cycle sample strobe
//   enable              1 = run tone, 0 = mute at MID_CODE
//   cfg_valid/ready     config handshake (ready = slot empty)
//   cfg_high_len        high-phase length in samples (0 acts as 1)
//   cfg_low_len         low-phase length (only with SQ_WAVE_DUTY_EN)
//   cfg_amp             amplitude
//   code                registered DAC sample code
//   phase_high          registered current phase
//   cycle_done          one-cycle pulse on each high->low transition
//
// Build option: define SQ_WAVE_DUTY_EN for an independent low-phase
// length (asymmetric duty). Without it the low phase mirrors high_len.

module tone_sq_wave_gen #(
    parameter int CODE_WIDTH       = 10,
    parameter int LEN_WIDTH        = 16,
    parameter int MID_CODE         = 512,
    parameter int DEFAULT_HIGH_LEN = 139,
    parameter int DEFAULT_AMP      = 50
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  next_sample,
    input  logic                  enable,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [LEN_WIDTH-1:0]  cfg_high_len,
`ifdef SQ_WAVE_DUTY_EN
    input  logic [LEN_WIDTH-1:0]  cfg_low_len,
`endif
    input  logic [CODE_WIDTH-2:0] cfg_amp,
    output logic [CODE_WIDTH-1:0] code,
    output logic                  phase_high,
    output logic                  cycle_done
);

    localparam int AW = CODE_WIDTH - 1;
    localparam int SW = CODE_WIDTH + 1;

    localparam logic [CODE_WIDTH-1:0] MID_C   = CODE_WIDTH'(MID_CODE);
    localparam logic [CODE_WIDTH-1:0] MAX_C   = {CODE_WIDTH{1'b1}};
    localparam logic [LEN_WIDTH-1:0]  DEF_LEN = LEN_WIDTH'(DEFAULT_HIGH_LEN);
    localparam logic [AW-1:0]         DEF_AMP = AW'(DEFAULT_AMP);
    localparam logic [LEN_WIDTH-1:0]  ONE_L   = LEN_WIDTH'(1);

    // ST_MUTE: not yet started since enable rose (or muted);
    // the first advance out of it is a boundary into ST_HIGH.
    typedef enum logic [1:0] {
        ST_MUTE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t                  state_q;
    logic [LEN_WIDTH-1:0]    cnt_q;
    logic [LEN_WIDTH-1:0]    high_len_q;
    logic [AW-1:0]           amp_q;
    logic                    pend_vld_q;
    logic [LEN_WIDTH-1:0]    pend_len_q;
    logic [AW-1:0]           pend_amp_q;
    logic [CODE_WIDTH-1:0]   code_q;
    logic                    phase_high_q;
    logic                    cycle_done_q;
`ifdef SQ_WAVE_DUTY_EN
    logic [LEN_WIDTH-1:0]    low_len_q;
    logic [LEN_WIDTH-1:0]    pend_low_q;
`endif

    logic                    adv;
    logic [LEN_WIDTH-1:0]    hl_eff;
    logic [LEN_WIDTH-1:0]    ll_eff;
    logic [LEN_WIDTH-1:0]    cur_len;
    logic                    boundary;
    logic                    apply;
    logic                    capture;
    logic [AW-1:0]           amp_nx;
    logic [SW-1:0]           hi_sum;
    logic [SW-1:0]           lo_dif;
    logic [CODE_WIDTH-1:0]   hi_code;
    logic [CODE_WIDTH-1:0]   lo_code;

    always_comb begin
        adv    = enable & next_sample;
        hl_eff = (high_len_q == '0) ? ONE_L : high_len_q;
`ifdef SQ_WAVE_DUTY_EN
        ll_eff = (low_len_q == '0) ? ONE_L : low_len_q;
`else
        ll_eff = hl_eff;
`endif
        cur_len  = (state_q == ST_HIGH) ? hl_eff : ll_eff;
        boundary = adv & ((state_q == ST_MUTE) | (cnt_q == cur_len - ONE_L));
        // Slot is only applied if it was already full at cycle start,
        // so a same-cycle capture waits for the following boundary.
        apply    = pend_vld_q & (boundary | ~enable);
        capture  = cfg_valid & ~pend_vld_q;
        // Code for the phase starting now must use the amp applied now.
        amp_nx   = apply ? pend_amp_q : amp_q;
        hi_sum   = SW'(MID_C) + SW'(amp_nx);
        lo_dif   = SW'(MID_C) - SW'(amp_nx);
        hi_code  = (hi_sum > SW'(MAX_C)) ? MAX_C : hi_sum[CODE_WIDTH-1:0];
        lo_code  = lo_dif[SW-1] ? '0 : lo_dif[CODE_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_MUTE;
            cnt_q        <= '0;
            high_len_q   <= DEF_LEN;
            amp_q        <= DEF_AMP;
            pend_vld_q   <= 1'b0;
            pend_len_q   <= '0;
            pend_amp_q   <= '0;
            code_q       <= MID_C;
            phase_high_q <= 1'b0;
            cycle_done_q <= 1'b0;
`ifdef SQ_WAVE_DUTY_EN
            low_len_q    <= DEF_LEN;
            pend_low_q   <= '0;
`endif
        end else begin
            if (capture) begin
                pend_vld_q <= 1'b1;
                pend_len_q <= cfg_high_len;
                pend_amp_q <= cfg_amp;
`ifdef SQ_WAVE_DUTY_EN
                pend_low_q <= cfg_low_len;
`endif
            end else if (apply) begin
                pend_vld_q <= 1'b0;
            end

            if (apply) begin
                high_len_q <= pend_len_q;
                amp_q      <= pend_amp_q;
`ifdef SQ_WAVE_DUTY_EN
                low_len_q  <= pend_low_q;
`endif
            end

            cycle_done_q <= 1'b0;

            if (!enable) begin
                state_q      <= ST_MUTE;
                cnt_q        <= '0;
                phase_high_q <= 1'b0;
                code_q       <= MID_C;
            end else if (boundary) begin
                cnt_q <= '0;
                unique case (state_q)
                    ST_HIGH: begin
                        state_q      <= ST_LOW;
                        phase_high_q <= 1'b0;
                        code_q       <= lo_code;
                        cycle_done_q <= 1'b1;
                    end
                    default: begin
                        state_q      <= ST_HIGH;
                        phase_high_q <= 1'b1;
                        code_q       <= hi_code;
                    end
                endcase
            end else if (adv) begin
                cnt_q <= cnt_q + ONE_L;
            end
        end
    end

    assign cfg_ready  = ~pend_vld_q;
    assign code       = code_q;
    assign phase_high = phase_high_q;
    assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_tone_sq_wave_gen.sv
// tb_tone_sq_wave_gen: directed self-checking bench for tone_sq_wave_gen.
// Linear step sequence; each check is an immediate assertion.

module tb_tone_sq_wave_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       next_sample = 1'b0;
    logic       enable = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [15:0] cfg_high_len = '0;
`ifdef SQ_WAVE_DUTY_EN
    logic [15:0] cfg_low_len = '0;
`endif
    logic [8:0] cfg_amp = '0;
    logic [9:0] code;
    logic       phase_high;
    logic       cycle_done;

    int total = 0;
    int bad = 0;
    int cd_cnt = 0;
    bit cd_wide = 1'b0;

    always #5 clk = ~clk;

    tone_sq_wave_gen dut (
        .clk          (clk),
        .rst          (rst),
        .next_sample  (next_sample),
        .enable       (enable),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_high_len (cfg_high_len),
`ifdef SQ_WAVE_DUTY_EN
        .cfg_low_len  (cfg_low_len),
`endif
        .cfg_amp      (cfg_amp),
        .code         (code),
        .phase_high   (phase_high),
        .cycle_done   (cycle_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One strobe every 4 clocks; cycle_done must show only right after it.
    task automatic strobe();
        next_sample = 1'b1;
        tick();
        next_sample = 1'b0;
        if (cycle_done === 1'b1) cd_cnt++;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (cycle_done !== 1'b0) cd_wide = 1'b1;
        end
    endtask

    task automatic offer(input int hl, input int ll, input int amp);
        cfg_valid    = 1'b1;
        cfg_high_len = 16'(hl);
`ifdef SQ_WAVE_DUTY_EN
        cfg_low_len  = 16'(ll);
`else
        if (ll != hl) $display("note: low len %0d unused", ll);
`endif
        cfg_amp      = 9'(amp);
        tick();
        cfg_valid    = 1'b0;
    endtask

    // Phase already showing want for n0 strobes; count until it changes.
    task automatic measure(input logic [9:0] want, input int n0,
                           input int len, input string tag);
        int  n;
        bit  done;
        n    = n0;
        done = 1'b0;
        chk({tag, "_code"}, 32'(code), 32'(want));
        for (int i = 0; i < 2000 && !done; i++) begin
            strobe();
            if (code !== want) done = 1'b1;
            else n++;
        end
        chk({tag, "_len"}, 32'(n), 32'(len));
    endtask

    initial begin
        // reset
        #2 rst = 1'b1;
        tick();
        tick();
        chk("rst_code", 32'(code), 512);
        chk("rst_phase", 32'(phase_high), 0);
        chk("rst_done", 32'(cycle_done), 0);
        chk("rst_ready", 32'(cfg_ready), 1);
        rst = 1'b0;
        tick();

        // defaults, 50% duty, 139/139
        enable = 1'b1;
        tick();
        tick();
        chk("pre_run_code", 32'(code), 512);
        chk("pre_run_phase", 32'(phase_high), 0);
        strobe();
        chk("first_phase", 32'(phase_high), 1);
        measure(10'd562, 1, 139, "hi0");
        chk("lo0_phase", 32'(phase_high), 0);
        measure(10'd462, 1, 139, "lo0");
        measure(10'd562, 1, 139, "hi1");
        chk("cd_after_hi1", 32'(cd_cnt), 2);
        measure(10'd462, 1, 139, "lo1");

        // config mid high phase: len 10, amp 200
        for (int i = 0; i < 5; i++) strobe();
        offer(10, 10, 200);
        chk("cfg_ready_low", 32'(cfg_ready), 0);
        measure(10'd562, 6, 139, "hi_wait");
        chk("cfg_ready_back", 32'(cfg_ready), 1);
        measure(10'd312, 1, 10, "lo_cfg");
        measure(10'd712, 1, 10, "hi_cfg");

        // saturation: amp 511, len 4
        offer(4, 4, 511);
        measure(10'd312, 1, 10, "lo_pre");
        measure(10'd1023, 1, 4, "hi511");
        measure(10'd1, 1, 4, "lo511");

        // capture in the same cycle as a toggle
        for (int i = 0; i < 3; i++) strobe();
        chk("pre_tog_code", 32'(code), 1023);
        next_sample  = 1'b1;
        cfg_valid    = 1'b1;
        cfg_high_len = 16'd6;
`ifdef SQ_WAVE_DUTY_EN
        cfg_low_len  = 16'd6;
`endif
        cfg_amp      = 9'd100;
        tick();
        next_sample = 1'b0;
        cfg_valid   = 1'b0;
        chk("tog_cd", 32'(cycle_done), 1);
        if (cycle_done === 1'b1) cd_cnt++;
        tick();
        tick();
        tick();
        chk("tog_ready", 32'(cfg_ready), 0);
        measure(10'd1, 1, 4, "lo_hold");
        chk("hold_ready", 32'(cfg_ready), 1);
        measure(10'd612, 1, 6, "hi_new");
        chk("cd_after_new", 32'(cd_cnt), 7);

        // mute mid phase, then re-enable
        strobe();
        strobe();
        enable = 1'b0;
        tick();
        chk("mute_code", 32'(code), 512);
        chk("mute_phase", 32'(phase_high), 0);
        strobe();
        strobe();
        chk("mute_hold", 32'(code), 512);
        enable = 1'b1;
        tick();
        strobe();
        chk("reen_phase", 32'(phase_high), 1);
        measure(10'd612, 1, 6, "hi_reen");

        // async reset mid phase with a pending config
        strobe();
        strobe();
        offer(2, 2, 5);
        chk("pend_ready", 32'(cfg_ready), 0);
        #3 rst = 1'b1;
        #1;
        chk("arst_code", 32'(code), 512);
        chk("arst_phase", 32'(phase_high), 0);
        chk("arst_ready", 32'(cfg_ready), 1);
        chk("arst_done", 32'(cycle_done), 0);
        #2 rst = 1'b0;
        tick();
        strobe();
        measure(10'd562, 1, 139, "hi_post_rst");
        chk("lo_post_rst", 32'(code), 462);
        chk("cd_total", 32'(cd_cnt), 9);
        chk("cd_width", 32'(cd_wide), 0);

`ifdef SQ_WAVE_DUTY_EN
        // asymmetric duty: high 3, low 7, amp 100
        enable = 1'b0;
        offer(3, 7, 100);
        tick();
        enable = 1'b1;
        tick();
        strobe();
        measure(10'd612, 1, 3, "duty_hi");
        measure(10'd412, 1, 7, "duty_lo");
        chk("duty_wrap", 32'(code), 612);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
